uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 155 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner selection for one shared UART transmitter.
// Each grant sends HEADER then the owner's latched byte, with a per-byte timeout.
module uart_tx_arbiter #(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] HEADER  = 8'h52,
  parameter int         TIMEOUT = 200000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   ack,
  output logic               timeout_err,
  output logic               busy,
  output logic               tx_start,
  output logic [7:0]         tx_byte,
  input  logic               tx_busy,
  input  logic               tx_done
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, HDR, WAIT_HDR, PAY, WAIT_PAY
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IW-1:0]    win_q, win_d;
  logic [IW-1:0]    last_q, last_d;
  logic [7:0]       pay_q, pay_d;
  logic [7:0]       byte_q, byte_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             terr;

  logic [IW-1:0]    pick;
  logic             any_req;
  logic [N_REQ-1:0] pick_oh;
  logic [7:0]       pick_data;

  // Descending scan so the closest requester after last wins.
  always_comb begin
    pick    = last_q;
    any_req = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[IW'((int'(last_q) + i) % N_REQ)]) begin
        pick    = IW'((int'(last_q) + i) % N_REQ);
        any_req = 1'b1;
      end
    end
    pick_oh   = '0;
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick == IW'(i)) begin
        pick_oh[i] = 1'b1;
        pick_data  = req_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      win_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      pay_q   <= '0;
      byte_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      win_q   <= win_d;
      last_q  <= last_d;
      pay_q   <= pay_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    win_d   = win_q;
    last_d  = last_q;
    pay_d   = pay_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    terr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Hold off during the ack cycle so the finished owner can drop req.
        if (!tx_busy && any_req && ~|ack_q) begin
          grant_d = pick_oh;
          win_d   = pick;
          pay_d   = pick_data;
          byte_d  = HEADER;
          state_d = HDR;
        end
      end
      HDR: begin
        cnt_d   = '0;
        state_d = WAIT_HDR;
      end
      WAIT_HDR: begin
        if (tx_done) begin
          byte_d  = pay_q;
          state_d = PAY;
        end else if (cnt_q == CNT_LAST) begin
          terr    = 1'b1;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PAY: begin
        cnt_d   = '0;
        state_d = WAIT_PAY;
      end
      WAIT_PAY: begin
        if (tx_done) begin
          ack_d   = grant_q;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          terr    = 1'b1;
          grant_d = '0;
          last_d  = win_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign ack         = ack_q;
  assign timeout_err = terr;
  assign busy        = (state_q != IDLE);
  assign tx_start    = (state_q == HDR) || (state_q == PAY);
  assign tx_byte     = byte_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scenario tasks plus a queue-based frame/arbitration model
// and a simple byte-level transmitter model.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int TO = 50;
  localparam logic [7:0] HB = 8'h52;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] req_data = '0;
  logic tx_busy = 1'b0;
  logic tx_done = 1'b0;
  logic [N-1:0] grant, ack;
  logic timeout_err, busy, tx_start;
  logic [7:0] tx_byte;

  uart_tx_arbiter #(.N_REQ(N), .HEADER(HB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .ack(ack), .timeout_err(timeout_err),
    .busy(busy), .tx_start(tx_start), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit model_en = 1'b1;
  bit churn = 1'b0;
  int lat = 10;
  int cd = 0;
  logic [7:0] sent_q[$];
  logic [7:0] exp_b[$];
  int act_g[$];
  int exp_g[$];
  int ack_cnt = 0;
  int terr_cnt = 0;
  int inv_bad = 0;
  int st_cyc = 0;
  int terr_cyc = 0;
  int m_last = N - 1;
  int owner = 0;
  logic [N-1:0] prev_g = '0;

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor + reference model first, then the transmitter model drives tx_done.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        cd = 0; tx_done = 1'b0; m_last = N - 1; prev_g = '0;
      end else begin
        if (!$onehot0(grant)) inv_bad++;
        if ((ack != 0) && timeout_err) inv_bad++;
        if (ack != 0) begin
          ack_cnt++;
          if (ack != (4'b0001 << owner)) inv_bad++;
          m_last = owner;
        end
        if (timeout_err) begin
          terr_cnt++; terr_cyc = cyc; m_last = owner;
        end
        if ((grant != 0) && (prev_g == 0)) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
          exp_g.push_back(w);
          owner = idx_of(grant);
          act_g.push_back(owner);
          exp_b.push_back(HB);
          exp_b.push_back((w >= 0) ? req_data[8*w +: 8] : 8'h00);
        end
        prev_g = grant;
        tx_done = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) tx_done = 1'b1;
        end
        if (tx_start) begin
          sent_q.push_back(tx_byte);
          st_cyc = cyc;
          if (model_en) cd = lat;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_logs();
    sent_q.delete(); exp_b.delete(); act_g.delete(); exp_g.delete();
    ack_cnt = 0; terr_cnt = 0; inv_bad = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; tx_busy = 1'b0; model_en = 1'b1; churn = 1'b0; lat = 10;
    step(2);
    rst = 1'b0;
    clear_logs();
    step(1);
  endtask

  task automatic wait_ack(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (churn) begin req_data = $urandom(); lat = $urandom_range(1, 15); end
      if (ack_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    step(2);
    n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL rst_grant: got %b want 0", grant); end
    n_cmp++; if (ack !== '0) begin n_bad++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_terr: got %b want 0", timeout_err); end
    n_cmp++; if (tx_start !== 1'b0) begin n_bad++; $display("FAIL rst_txstart: got %b want 0", tx_start); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL rst_txbyte: got %h want 00", tx_byte); end
    rst = 1'b0;
    step(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    req_data = $urandom();
    req_data[7:0] = 8'hA5;
    req = 4'b0001;
    step(1);
    n_cmp++; if (grant !== 4'b0001) begin n_bad++; $display("FAIL single_grant_lat: got %b want 0001", grant); end
    n_cmp++; if (tx_start !== 1'b1) begin n_bad++; $display("FAIL single_hdr_start: got %b want 1", tx_start); end
    n_cmp++; if (tx_byte !== HB) begin n_bad++; $display("FAIL single_hdr_byte: got %h want %h", tx_byte, HB); end
    wait_ack(1, 100, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_ack_wait: got timeout want ack"); end
    n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL single_ack: got %b want 0001", ack); end
    req = '0;
    step(3);
    n_cmp++; if (grant !== '0) begin n_bad++; $display("FAIL single_grant_clr: got %b want 0", grant); end
    n_cmp++; if (ack_cnt != 1) begin n_bad++; $display("FAIL single_ack_cnt: got %0d want 1", ack_cnt); end
    n_cmp++; if (sent_q.size() != 2) begin n_bad++; $display("FAIL single_nbytes: got %0d want 2", sent_q.size()); end
    else begin
      n_cmp++; if (sent_q[0] !== HB) begin n_bad++; $display("FAIL single_b0: got %h want %h", sent_q[0], HB); end
      n_cmp++; if (sent_q[1] !== 8'hA5) begin n_bad++; $display("FAIL single_b1: got %h want a5", sent_q[1]); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    churn = 1'b1;
    req_data = $urandom();
    req = 4'b1111;
    wait_ack(8, 600, ok);
    req = '0;
    churn = 1'b0;
    step(5);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_ack_wait: got %0d acks want 8", ack_cnt); end
    n_cmp++; if (act_g.size() != 8) begin n_bad++; $display("FAIL rr_frames: got %0d want 8", act_g.size()); end
    else for (int i = 0; i < 8; i++) begin
      n_cmp++; if (act_g[i] != order[i]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, act_g[i], order[i]); end
    end
    n_cmp++; if (sent_q.size() != 16) begin n_bad++; $display("FAIL rr_nbytes: got %0d want 16", sent_q.size()); end
    else for (int i = 0; i < 16; i++) begin
      n_cmp++; if (sent_q[i] !== exp_b[i]) begin n_bad++; $display("FAIL rr_byte[%0d]: got %h want %h", i, sent_q[i], exp_b[i]); end
    end
    n_cmp++; if (inv_bad != 0) begin n_bad++; $display("FAIL rr_invariants: got %0d want 0", inv_bad); end
  endtask

  task automatic test_timeout();
    bit ok;
    int g1;
    do_reset();
    model_en = 1'b0;
    req_data = $urandom();
    req = 4'b0011;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1);
      if (terr_cnt > 0) begin ok = 1'b1; break; end
    end
    model_en = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL to_wait: got no timeout_err want pulse"); end
    n_cmp++; if (terr_cyc - st_cyc != TO) begin n_bad++; $display("FAIL to_delay: got %0d want %0d", terr_cyc - st_cyc, TO); end
    for (int i = 0; i < 20; i++) begin
      if (act_g.size() >= 2) break;
      step(1);
    end
    g1 = (act_g.size() >= 2) ? act_g[1] : -1;
    n_cmp++; if (g1 != 1) begin n_bad++; $display("FAIL to_next_grant: got %0d want 1", g1); end
    req = 4'b0010;
    wait_ack(1, 100, ok);
    req = '0;
    step(3);
    n_cmp++; if (ack_cnt != 1) begin n_bad++; $display("FAIL to_ack_cnt: got %0d want 1", ack_cnt); end
    n_cmp++; if (terr_cnt != 1) begin n_bad++; $display("FAIL to_terr_cnt: got %0d want 1", terr_cnt); end
  endtask

  task automatic test_latch();
    bit ok;
    do_reset();
    req_data = $urandom();
    req_data[7:0] = 8'h11;
    req = 4'b0001;
    step(2);
    req_data[7:0] = 8'h22;
    req = '0;
    wait_ack(1, 100, ok);
    step(2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL latch_ack: got no ack want ack"); end
    n_cmp++; if (sent_q.size() != 2) begin n_bad++; $display("FAIL latch_nbytes: got %0d want 2", sent_q.size()); end
    else begin
      n_cmp++; if (sent_q[1] !== 8'h11) begin n_bad++; $display("FAIL latch_payload: got %h want 11", sent_q[1]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] d2;
    int g0;
    do_reset();
    req_data = $urandom();
    req = 4'b0001;
    for (int i = 0; i < 100; i++) begin
      if (sent_q.size() >= 2) break;
      step(1);
    end
    step(3);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_pre: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({grant, ack, timeout_err, tx_start, busy} !== '0) begin
      n_bad++; $display("FAIL mid_rst_outs: got %b want 0", {grant, ack, timeout_err, tx_start, busy}); end
    n_cmp++; if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL mid_rst_byte: got %h want 00", tx_byte); end
    step(15);
    n_cmp++; if (ack_cnt + terr_cnt != 0) begin n_bad++; $display("FAIL mid_no_pulse: got %0d want 0", ack_cnt + terr_cnt); end
    req = '0;
    rst = 1'b0;
    clear_logs();
    step(1);
    req_data = $urandom();
    d2 = req_data[23:16];
    req = 4'b0100;
    wait_ack(1, 100, ok);
    req = '0;
    step(2);
    g0 = (act_g.size() > 0) ? act_g[0] : -1;
    n_cmp++; if (g0 != 2) begin n_bad++; $display("FAIL mid_grant: got %0d want 2", g0); end
    n_cmp++; if (sent_q.size() != 2) begin n_bad++; $display("FAIL mid_nbytes: got %0d want 2", sent_q.size()); end
    else begin
      n_cmp++; if (sent_q[0] !== HB) begin n_bad++; $display("FAIL mid_hdr: got %h want %h", sent_q[0], HB); end
      n_cmp++; if (sent_q[1] !== d2) begin n_bad++; $display("FAIL mid_pay: got %h want %h", sent_q[1], d2); end
    end
  endtask

  task automatic test_busy_hold();
    bit ok;
    int early;
    do_reset();
    req_data = $urandom();
    tx_busy = 1'b1;
    req = 4'b0010;
    early = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (grant != 0) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL busy_no_grant: got %0d want 0", early); end
    tx_busy = 1'b0;
    step(1);
    n_cmp++; if (grant !== 4'b0010) begin n_bad++; $display("FAIL busy_grant: got %b want 0010", grant); end
    wait_ack(1, 100, ok);
    req = '0;
    step(2);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_ack: got no ack want ack"); end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    ok = 1'b0;
    for (int s = 0; s < 4000; s++) begin
      step(1);
      req_data = $urandom();
      lat = $urandom_range(1, 15);
      tx_busy = ($urandom_range(0, 7) == 0);
      if (ack != 0) req = req & ~ack;
      else for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      if (ack_cnt >= 30) begin ok = 1'b1; break; end
    end
    req = '0;
    tx_busy = 1'b0;
    step(3);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rnd_frames: got %0d acks want 30", ack_cnt); end
    n_cmp++; if (act_g.size() != exp_g.size()) begin n_bad++; $display("FAIL rnd_ngrants: got %0d want %0d", act_g.size(), exp_g.size()); end
    else for (int i = 0; i < act_g.size(); i++) begin
      n_cmp++; if (act_g[i] != exp_g[i]) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %0d want %0d", i, act_g[i], exp_g[i]); end
    end
    n_cmp++; if (sent_q.size() != exp_b.size()) begin n_bad++; $display("FAIL rnd_nbytes: got %0d want %0d", sent_q.size(), exp_b.size()); end
    else for (int i = 0; i < sent_q.size(); i++) begin
      n_cmp++; if (sent_q[i] !== exp_b[i]) begin n_bad++; $display("FAIL rnd_byte[%0d]: got %h want %h", i, sent_q[i], exp_b[i]); end
    end
    n_cmp++; if (inv_bad != 0) begin n_bad++; $display("FAIL rnd_invariants: got %0d want 0", inv_bad); end
    n_cmp++; if (terr_cnt != 0) begin n_bad++; $display("FAIL rnd_terr: got %0d want 0", terr_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_latch();
    test_reset_mid();
    test_busy_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
